// File: rtl/timer_ctrl.sv
// timer_ctrl: count-enable prescaler, disable clear pulse, debug halt and compare interrupt for the 64-bit timer
module timer_ctrl #(
    parameter int DIV_W   = 4,
    parameter int DIV_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             timer_en,
    input  logic             div_en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             dbg_mode,
    input  logic             halt_req,
    input  logic [63:0]      cnt,
    input  logic [63:0]      cmp,
    input  logic             int_en,
    input  logic             int_clr,
    output logic             cnt_en,
    output logic             timer_en_neg,
    output logic             halt_ack,
    output logic             int_st,
    output logic             tim_int
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t           state, state_nx;
    logic             timer_en_q, match_q, match, div_clr;
    logic [DIV_W-1:0] div_val_q, eff;
    logic [7:0]       div_cnt, limit;
    assign eff          = (div_val > DIV_W'(DIV_MAX)) ? DIV_W'(DIV_MAX) : div_val;
    assign limit        = 8'((9'd1 << eff) - 9'd1);
    assign div_clr      = (state == IDLE) | ~div_en | (div_val != div_val_q);
    assign match        = cnt == cmp;
    assign timer_en_neg = timer_en_q & ~timer_en;
    assign tim_int      = int_st & int_en;
    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // Next state; count enable and halt acknowledge decode from the registered state only
    always_comb begin
        state_nx = state;
        cnt_en   = 1'b0;
        halt_ack = 1'b0;
        case (state)
            IDLE: state_nx = timer_en ? RUN : IDLE;
            RUN: begin
                state_nx = !timer_en ? IDLE : (dbg_mode & halt_req) ? HALT : RUN;
                cnt_en   = ~div_en | (eff == '0) | (div_cnt == limit);
            end
            HALT: begin
                state_nx = !timer_en ? IDLE : (dbg_mode & halt_req) ? HALT : RUN;
                halt_ack = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end
    // Prescaler: restart on idle, disable or divisor change; freeze phase while halted
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            div_val_q <= '0;
        end else begin
            div_val_q <= div_val;
            if (div_clr)           div_cnt <= '0;
            else if (state == RUN) div_cnt <= (div_cnt == limit) ? '0 : div_cnt + 8'd1;
        end
    end
    // Enable edge history and sticky compare-match status; a new match beats a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_en_q <= 1'b0;
            match_q    <= 1'b1;
            int_st     <= 1'b0;
        end else begin
            timer_en_q <= timer_en;
            match_q    <= match;
            if (match & ~match_q) int_st <= 1'b1;
            else if (int_clr)     int_st <= 1'b0;
        end
    end
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed scenarios plus randomized run against a behavioural timer model
module tb_timer_ctrl;
    localparam int DIV_MAX = 8;
    logic clk = 1'b0;
    logic rst, timer_en, div_en, dbg_mode, halt_req, int_en, int_clr;
    logic [3:0] div_val;
    logic [63:0] cnt, cmp;
    logic cnt_en, timer_en_neg, halt_ack, int_st, tim_int;
    int n_chk = 0;
    int n_fail = 0;
    // Behavioural model: mode 0 idle, 1 run, 2 halt; prescaler phase derived from ticks since restart
    int m_mode, m_ticks, m_div_prev;
    bit m_en_q, m_match_q, m_int;

    timer_ctrl #(.DIV_W(4), .DIV_MAX(DIV_MAX)) dut (
        .clk(clk), .rst(rst), .timer_en(timer_en), .div_en(div_en), .div_val(div_val),
        .dbg_mode(dbg_mode), .halt_req(halt_req), .cnt(cnt), .cmp(cmp), .int_en(int_en),
        .int_clr(int_clr), .cnt_en(cnt_en), .timer_en_neg(timer_en_neg), .halt_ack(halt_ack),
        .int_st(int_st), .tim_int(tim_int)
    );

    always #5 clk = ~clk;

    function automatic int eff_of(input logic [3:0] v);
        return (int'(v) > DIV_MAX) ? DIV_MAX : int'(v);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode <= 0; m_ticks <= 0; m_div_prev <= 0;
            m_en_q <= 1'b0; m_match_q <= 1'b1; m_int <= 1'b0;
        end else begin
            m_en_q     <= timer_en;
            m_match_q  <= (cnt == cmp);
            m_div_prev <= int'(div_val);
            if (cnt == cmp && !m_match_q) m_int <= 1'b1;
            else if (int_clr)             m_int <= 1'b0;
            if (m_mode == 0 || !div_en || int'(div_val) != m_div_prev) m_ticks <= 0;
            else if (m_mode == 1)                                     m_ticks <= m_ticks + 1;
            m_mode <= !timer_en ? 0 : (m_mode != 0 && dbg_mode && halt_req) ? 2 : 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_en: got %b want 0", cnt_en); end
        n_chk++; if (timer_en_neg !== 1'b0) begin n_fail++; $display("FAIL reset_neg: got %b want 0", timer_en_neg); end
        n_chk++; if (halt_ack !== 1'b0) begin n_fail++; $display("FAIL reset_halt_ack: got %b want 0", halt_ack); end
        n_chk++; if (int_st !== 1'b0) begin n_fail++; $display("FAIL reset_int_st: got %b want 0", int_st); end
        n_chk++; if (tim_int !== 1'b0) begin n_fail++; $display("FAIL reset_tim_int: got %b want 0", tim_int); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            n_chk++; if (int_st !== 1'b0) begin n_fail++; $display("FAIL reset_no_int cyc%0d: got %b want 0", i, int_st); end
        end
    endtask

    task automatic test_div1();
        cyc();
        timer_en = 1'b1;
        div_en   = 1'b0;
        @(negedge clk);
        n_chk++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL div1_idle_cnt_en: got %b want 0", cnt_en); end
        for (int i = 0; i < 10; i++) begin
            cyc();
            @(negedge clk);
            n_chk++; if (cnt_en !== 1'b1) begin n_fail++; $display("FAIL div1_cnt_en cyc%0d: got %b want 1", i, cnt_en); end
        end
        cyc();
        timer_en = 1'b0;
        @(negedge clk);
        n_chk++; if (timer_en_neg !== 1'b1) begin n_fail++; $display("FAIL run_disable_neg: got %b want 1", timer_en_neg); end
        cyc();
        @(negedge clk);
        n_chk++; if (timer_en_neg !== 1'b0) begin n_fail++; $display("FAIL run_disable_neg_once: got %b want 0", timer_en_neg); end
        n_chk++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL run_disable_cnt_en: got %b want 0", cnt_en); end
    endtask

    task automatic test_prescale();
        cyc();
        div_en   = 1'b1;
        div_val  = 4'd2;
        timer_en = 1'b1;
        for (int r = 0; r < 12; r++) begin
            cyc();
            @(negedge clk);
            n_chk++; if (cnt_en !== (r % 4 == 3)) begin n_fail++; $display("FAIL div4 run%0d: got %b want %b", r, cnt_en, r % 4 == 3); end
        end
        cyc();
        div_val = 4'd1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            n_chk++; if (cnt_en !== (k >= 2 && k % 2 == 0)) begin n_fail++; $display("FAIL div_change k%0d: got %b want %b", k, cnt_en, k >= 2 && k % 2 == 0); end
            cyc();
        end
        div_val = 4'd12;
        for (int k = 0; k < 514; k++) begin
            @(negedge clk);
            n_chk++; if (cnt_en !== (k == 256 || k == 512)) begin n_fail++; $display("FAIL div_clamp k%0d: got %b want %b", k, cnt_en, k == 256 || k == 512); end
            cyc();
        end
        timer_en = 1'b0;
        cyc();
        cyc();
        div_en  = 1'b0;
        div_val = 4'd0;
    endtask

    task automatic test_halt();
        div_en   = 1'b1;
        div_val  = 4'd2;
        dbg_mode = 1'b1;
        timer_en = 1'b1;
        cyc();
        cyc();
        cyc();
        halt_req = 1'b1;
        @(negedge clk);
        n_chk++; if (halt_ack !== 1'b0) begin n_fail++; $display("FAIL halt_req_cycle_ack: got %b want 0", halt_ack); end
        for (int i = 1; i <= 5; i++) begin
            cyc();
            if (i == 5) halt_req = 1'b0;
            @(negedge clk);
            n_chk++; if (halt_ack !== 1'b1) begin n_fail++; $display("FAIL halt_ack cyc%0d: got %b want 1", i, halt_ack); end
            n_chk++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL halt_cnt_en cyc%0d: got %b want 0", i, cnt_en); end
        end
        cyc();
        @(negedge clk);
        n_chk++; if (halt_ack !== 1'b0) begin n_fail++; $display("FAIL resume_ack: got %b want 0", halt_ack); end
        n_chk++; if (cnt_en !== 1'b1) begin n_fail++; $display("FAIL resume_pulse: got %b want 1", cnt_en); end
        cyc();
        dbg_mode = 1'b0;
        halt_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_chk++; if (halt_ack !== 1'b0) begin n_fail++; $display("FAIL nodbg_ack cyc%0d: got %b want 0", i, halt_ack); end
            n_chk++; if (cnt_en !== (i == 3)) begin n_fail++; $display("FAIL nodbg_cnt_en cyc%0d: got %b want %b", i, cnt_en, i == 3); end
            cyc();
        end
        dbg_mode = 1'b1;
        cyc();
        @(negedge clk);
        n_chk++; if (halt_ack !== 1'b1) begin n_fail++; $display("FAIL halt2_ack: got %b want 1", halt_ack); end
        cyc();
        timer_en = 1'b0;
        @(negedge clk);
        n_chk++; if (timer_en_neg !== 1'b1) begin n_fail++; $display("FAIL halt_disable_neg: got %b want 1", timer_en_neg); end
        n_chk++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL halt_disable_cnt_en: got %b want 0", cnt_en); end
        cyc();
        @(negedge clk);
        n_chk++; if (timer_en_neg !== 1'b0) begin n_fail++; $display("FAIL halt_disable_neg_once: got %b want 0", timer_en_neg); end
        n_chk++; if (halt_ack !== 1'b0) begin n_fail++; $display("FAIL halt_disable_ack: got %b want 0", halt_ack); end
        halt_req = 1'b0;
        dbg_mode = 1'b0;
        div_en   = 1'b0;
        div_val  = 4'd0;
        cyc();
    endtask

    task automatic test_compare();
        cmp    = 64'h0000_0001_0000_0003;
        int_en = 1'b1;
        for (int v = 0; v < 6; v++) begin
            cnt = 64'h0000_0001_0000_0000 + 64'(v);
            @(negedge clk);
            n_chk++; if (int_st !== (v >= 4)) begin n_fail++; $display("FAIL cmp_int_st v%0d: got %b want %b", v, int_st, v >= 4); end
            n_chk++; if (tim_int !== (v >= 4)) begin n_fail++; $display("FAIL cmp_tim_int v%0d: got %b want %b", v, tim_int, v >= 4); end
            cyc();
        end
        cnt = cmp;
        cyc();
        int_clr = 1'b1;
        cyc();
        int_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++; if (int_st !== 1'b0) begin n_fail++; $display("FAIL frozen_match_int_st cyc%0d: got %b want 0", i, int_st); end
            cyc();
        end
        cnt = 64'd0;
        cyc();
        cnt = cmp;
        cyc();
        int_en = 1'b0;
        @(negedge clk);
        n_chk++; if (int_st !== 1'b1) begin n_fail++; $display("FAIL masked_int_st: got %b want 1", int_st); end
        n_chk++; if (tim_int !== 1'b0) begin n_fail++; $display("FAIL masked_tim_int: got %b want 0", tim_int); end
        cyc();
        cnt     = 64'd0;
        int_clr = 1'b1;
        cyc();
        cnt = cmp;
        @(negedge clk);
        n_chk++; if (int_st !== 1'b0) begin n_fail++; $display("FAIL clr_int_st: got %b want 0", int_st); end
        cyc();
        int_clr = 1'b0;
        int_en  = 1'b1;
        @(negedge clk);
        n_chk++; if (int_st !== 1'b1) begin n_fail++; $display("FAIL set_beats_clr: got %b want 1", int_st); end
        n_chk++; if (tim_int !== 1'b1) begin n_fail++; $display("FAIL set_beats_clr_tim_int: got %b want 1", tim_int); end
        cyc();
        cnt     = 64'd0;
        cmp     = 64'd0;
        int_clr = 1'b1;
        cyc();
        int_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        timer_en = 1'b1;
        cnt      = 64'd5;
        cyc();
        cnt = 64'd0;
        cyc();
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (int_st !== 1'b1) begin n_fail++; $display("FAIL pre_reset_int_st: got %b want 1", int_st); end
        n_chk++; if (cnt_en !== 1'b1) begin n_fail++; $display("FAIL pre_reset_cnt_en: got %b want 1", cnt_en); end
        cyc();
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL midrst_cnt_en: got %b want 0", cnt_en); end
        n_chk++; if (timer_en_neg !== 1'b0) begin n_fail++; $display("FAIL midrst_neg: got %b want 0", timer_en_neg); end
        n_chk++; if (halt_ack !== 1'b0) begin n_fail++; $display("FAIL midrst_halt_ack: got %b want 0", halt_ack); end
        n_chk++; if (int_st !== 1'b0) begin n_fail++; $display("FAIL midrst_int_st: got %b want 0", int_st); end
        n_chk++; if (tim_int !== 1'b0) begin n_fail++; $display("FAIL midrst_tim_int: got %b want 0", tim_int); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            @(negedge clk);
            n_chk++; if (int_st !== 1'b0) begin n_fail++; $display("FAIL post_rst_int cyc%0d: got %b want 0", i, int_st); end
        end
        timer_en = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_random();
        bit e_cnt_en, e_neg, e_ack;
        int ph, dn;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom % 200) == 0;
            if ($urandom % 20 == 0) timer_en = ~timer_en;
            if ($urandom % 25 == 0) div_en = ~div_en;
            if ($urandom % 40 == 0) div_val = 4'($urandom_range(0, 13));
            if ($urandom % 15 == 0) dbg_mode = ~dbg_mode;
            if ($urandom % 6 == 0) halt_req = ~halt_req;
            if ($urandom % 10 == 0) int_en = ~int_en;
            if ($urandom % 20 == 0) cmp = 64'($urandom_range(0, 3));
            cnt     = 64'($urandom_range(0, 3));
            int_clr = ($urandom % 8) == 0;
            @(negedge clk);
            ph = m_ticks % (1 << eff_of(4'(m_div_prev)));
            dn = 1 << eff_of(div_val);
            e_cnt_en = (m_mode == 1) && (!div_en || ph == dn - 1);
            e_neg    = m_en_q && !timer_en;
            e_ack    = m_mode == 2;
            n_chk++; if (cnt_en !== e_cnt_en) begin n_fail++; $display("FAIL rnd_cnt_en cyc%0d: got %b want %b", i, cnt_en, e_cnt_en); end
            n_chk++; if (timer_en_neg !== e_neg) begin n_fail++; $display("FAIL rnd_neg cyc%0d: got %b want %b", i, timer_en_neg, e_neg); end
            n_chk++; if (halt_ack !== e_ack) begin n_fail++; $display("FAIL rnd_halt_ack cyc%0d: got %b want %b", i, halt_ack, e_ack); end
            n_chk++; if (int_st !== m_int) begin n_fail++; $display("FAIL rnd_int_st cyc%0d: got %b want %b", i, int_st, m_int); end
            n_chk++; if (tim_int !== (m_int & int_en)) begin n_fail++; $display("FAIL rnd_tim_int cyc%0d: got %b want %b", i, tim_int, m_int & int_en); end
            cyc();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; timer_en = 1'b0; div_en = 1'b0; div_val = 4'd0; dbg_mode = 1'b0;
        halt_req = 1'b0; cnt = 64'd0; cmp = 64'd0; int_en = 1'b0; int_clr = 1'b0;
        test_reset();
        test_div1();
        test_prescale();
        test_halt();
        test_compare();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
